irq_ctrl: RTL and testbench

//  Parametrised platform interrupt controller; generalises the single ei line

---
 rtl/irq_ctrl.sv | 156 +++++++++++++++
 tb/tb_irq_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Platform interrupt controller: N_SRC prioritised, maskable sources with claim/complete gating.
// Latency: bus_ack/bus_rdata one cycle after bus_req; ei one cycle after any pending/enable/prio/thr change.
// Backpressure: none, every access is accepted and acked. IRQ_EDGE_EN adds per-source rising-edge mode.
module irq_ctrl #(
    parameter int N_SRC  = 8,
    parameter int PRIO_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC-1:0]  src,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [5:0]        bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic              bus_ack,
    output logic              ei
);

    localparam logic [5:0] A_PEND  = 6'h00;
    localparam logic [5:0] A_EN    = 6'h01;
    localparam logic [5:0] A_THR   = 6'h02;
    localparam logic [5:0] A_CLAIM = 6'h03;
`ifdef IRQ_EDGE_EN
    localparam logic [5:0] A_EDGE  = 6'h04;
`endif

    logic [N_SRC-1:0]  pending;
    logic [N_SRC-1:0]  in_service;
    logic [N_SRC-1:0]  enable;
    logic [PRIO_W-1:0] threshold;
    logic [PRIO_W-1:0] prio [N_SRC];

    logic [N_SRC-1:0]  eligible;
    logic [N_SRC-1:0]  set_vec;
    logic [N_SRC-1:0]  claim_clr;
    logic [N_SRC-1:0]  cmpl_clr;
    logic [4:0]        win_id;
    logic [PRIO_W-1:0] win_prio;
    logic [31:0]       rd_mux;
    logic              rd_req;
    logic              wr_req;
    logic              claim;
    logic              complete;
    logic              unused_wdata;

    assign unused_wdata = ^bus_wdata;

    assign rd_req   = bus_req & ~bus_we;
    assign wr_req   = bus_req & bus_we;
    assign claim    = rd_req & (bus_addr == A_CLAIM);
    assign complete = wr_req & (bus_addr == A_CLAIM);

`ifdef IRQ_EDGE_EN
    logic [N_SRC-1:0] edge_mode;
    logic [N_SRC-1:0] src_q;

    // Edge-mode sources may re-pend while in service; level-mode ones are gated by it.
    assign set_vec = (edge_mode & src & ~src_q) | (~edge_mode & src & ~in_service);
`else
    assign set_vec = src & ~in_service;
`endif

    // In-service sources are excluded so an edge-mode re-pend cannot be claimed twice.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            eligible[i] = pending[i] & enable[i] & ~in_service[i] & (prio[i] > threshold);
        end
    end

    // Strict compare while scanning upward keeps the lowest ID on priority ties.
    always_comb begin
        win_id   = '0;
        win_prio = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (eligible[i] && (prio[i] > win_prio)) begin
                win_prio = prio[i];
                win_id   = 5'(i + 1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            claim_clr[i] = claim && (win_id == 5'(i + 1));
            cmpl_clr[i]  = complete && (bus_wdata[4:0] == 5'(i + 1));
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus_addr)
            A_PEND:  rd_mux = 32'(pending);
            A_EN:    rd_mux = 32'(enable);
            A_THR:   rd_mux = 32'(threshold);
            A_CLAIM: rd_mux = 32'(win_id);
`ifdef IRQ_EDGE_EN
            A_EDGE:  rd_mux = 32'(edge_mode);
`endif
            default: rd_mux = '0;
        endcase
        for (int i = 0; i < N_SRC; i++) begin
            if (bus_addr == 6'(16 + i)) begin
                rd_mux = 32'(prio[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending    <= '0;
            in_service <= '0;
            enable     <= '0;
            threshold  <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                prio[i] <= '0;
            end
            bus_ack    <= 1'b0;
            bus_rdata  <= '0;
            ei         <= 1'b0;
        end else begin
            // Claim clear has priority over a same-edge set from a still-high source.
            pending    <= (pending | set_vec) & ~claim_clr;
            in_service <= (in_service | claim_clr) & ~cmpl_clr;
            bus_ack    <= bus_req;
            bus_rdata  <= rd_req ? rd_mux : '0;
            ei         <= |eligible;
            if (wr_req && bus_addr == A_EN) begin
                enable <= bus_wdata[N_SRC-1:0];
            end
            if (wr_req && bus_addr == A_THR) begin
                threshold <= bus_wdata[PRIO_W-1:0];
            end
            for (int i = 0; i < N_SRC; i++) begin
                if (wr_req && bus_addr == 6'(16 + i)) begin
                    prio[i] <= bus_wdata[PRIO_W-1:0];
                end
            end
        end
    end

`ifdef IRQ_EDGE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_mode <= '0;
            src_q     <= '0;
        end else begin
            src_q <= src;
            if (wr_req && bus_addr == A_EDGE) begin
                edge_mode <= bus_wdata[N_SRC-1:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomised and directed bench for irq_ctrl against a per-edge behavioural model.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  src = '0;
    logic        bus_req = 1'b0;
    logic        bus_we = 1'b0;
    logic [5:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        ei;

    int n_cmp = 0;
    int n_bad = 0;

    irq_ctrl #(.N_SRC(8), .PRIO_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .src       (src),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .ei        (ei)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  m_pend, m_ins, m_en, m_edge, m_srcq;
    logic [2:0]  m_thr;
    logic [2:0]  m_prio [8];
    logic        exp_ack, exp_ei;
    logic [31:0] exp_rdata;

    function automatic bit m_elig(input int i);
        return m_pend[i] && m_en[i] && !m_ins[i] && (m_prio[i] > m_thr);
    endfunction

    // Search from the highest priority level down; first hit in ID order wins.
    function automatic int m_winner();
        for (int p = 7; p >= 1; p--)
            for (int i = 0; i < 8; i++)
                if (m_elig(i) && m_prio[i] == p) return i + 1;
        return 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] a);
        if (a == 6'h00) return {24'd0, m_pend};
        if (a == 6'h01) return {24'd0, m_en};
        if (a == 6'h02) return {29'd0, m_thr};
        if (a == 6'h03) return 32'(m_winner());
        if (a == 6'h04) return {24'd0, m_edge};
        if (a >= 6'h10 && a <= 6'h17) return {29'd0, m_prio[a - 6'h10]};
        return 32'd0;
    endfunction

    task automatic model_step(input logic req, input logic we, input logic [5:0] a, input logic [31:0] wd);
        int w;
        int id;
        logic [7:0] np, ni;
        w = m_winner();
        exp_ack = req;
        exp_rdata = (req && !we) ? m_read(a) : 32'd0;
        exp_ei = 1'b0;
        for (int i = 0; i < 8; i++) if (m_elig(i)) exp_ei = 1'b1;
        np = m_pend;
        ni = m_ins;
        for (int i = 0; i < 8; i++) begin
            if (m_edge[i] ? (src[i] && !m_srcq[i]) : (src[i] && !m_ins[i])) np[i] = 1'b1;
        end
        if (req && !we && a == 6'h03 && w != 0) begin
            np[w-1] = 1'b0;
            ni[w-1] = 1'b1;
        end
        if (req && we) begin
            id = int'(wd[4:0]);
            if (a == 6'h03 && id >= 1 && id <= 8 && m_ins[id-1]) ni[id-1] = 1'b0;
            if (a == 6'h01) m_en = wd[7:0];
            if (a == 6'h02) m_thr = wd[2:0];
`ifdef IRQ_EDGE_EN
            if (a == 6'h04) m_edge = wd[7:0];
`endif
            if (a >= 6'h10 && a <= 6'h17) m_prio[a - 6'h10] = wd[2:0];
        end
        m_pend = np;
        m_ins  = ni;
        m_srcq = src;
    endtask

    // One clock: drive at the falling edge, model the rising edge, return at the next falling edge.
    task automatic tick(input logic req, input logic we, input logic [5:0] a, input logic [31:0] wd);
        bus_req = req;
        bus_we = we;
        bus_addr = a;
        bus_wdata = wd;
        model_step(req, we, a, wd);
        @(posedge clk);
        @(negedge clk);
        bus_req = 1'b0;
        bus_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 6'h00, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        m_pend = '0; m_ins = '0; m_en = '0; m_edge = '0; m_srcq = '0; m_thr = '0;
        for (int i = 0; i < 8; i++) m_prio[i] = '0;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        src = 8'hFF;
        bus_req = 1'b1;
        bus_we = 1'b0;
        bus_addr = 6'h00;
        @(negedge clk);
        do_reset();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (ei !== 1'b0) begin n_bad++; $display("FAIL reset_ei got %0b want 0", ei); end
        n_cmp++; if (bus_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %0b want 0", bus_ack); end
        n_cmp++; if (bus_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", bus_rdata); end
        rst = 1'b1;
        foreach (m_prio[i]) begin
            tick(1'b1, 1'b0, 6'(16 + i), 32'd0);
            n_cmp++; if (bus_rdata !== exp_rdata) begin n_bad++; $display("FAIL reset_prio%0d got %h want %h", i, bus_rdata, exp_rdata); end
        end
        tick(1'b1, 1'b0, 6'h01, 32'd0);
        n_cmp++; if (bus_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_enable got %h want 0", bus_rdata); end
        tick(1'b1, 1'b0, 6'h02, 32'd0);
        n_cmp++; if (bus_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_thr got %h want 0", bus_rdata); end
        tick(1'b1, 1'b1, 6'h01, 32'hFF);
        tick(1'b1, 1'b0, 6'h00, 32'd0);
        n_cmp++; if (bus_rdata !== 32'hFF) begin n_bad++; $display("FAIL reset_first_pending got %h want ff", bus_rdata); end
        n_cmp++; if (ei !== exp_ei) begin n_bad++; $display("FAIL reset_ei_prio0 got %0b want %0b", ei, exp_ei); end
    endtask

    task automatic test_priority();
        logic [31:0] want [4];
        want[0] = 32'd2; want[1] = 32'd3; want[2] = 32'd7; want[3] = 32'd0;
        do_reset();
        src = 8'h00;
        tick(1'b1, 1'b1, 6'h12, 32'd5);
        tick(1'b1, 1'b1, 6'h16, 32'd5);
        tick(1'b1, 1'b1, 6'h11, 32'd7);
        tick(1'b1, 1'b1, 6'h01, 32'hFF);
        tick(1'b1, 1'b1, 6'h02, 32'd0);
        src = 8'h46;
        idle(1);
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 1'b0, 6'h03, 32'd0);
            n_cmp++; if (bus_rdata !== want[k] || bus_rdata !== exp_rdata) begin
                n_bad++; $display("FAIL claim_order[%0d] got %0d want %0d", k, bus_rdata, want[k]);
            end
        end
    endtask

    task automatic test_threshold();
        do_reset();
        src = 8'h08;
        tick(1'b1, 1'b1, 6'h01, 32'hFF);
        tick(1'b1, 1'b1, 6'h13, 32'd5);
        tick(1'b1, 1'b1, 6'h02, 32'd5);
        idle(3);
        n_cmp++; if (ei !== 1'b0) begin n_bad++; $display("FAIL thr_masked_ei got %0b want 0", ei); end
        tick(1'b1, 1'b1, 6'h02, 32'd4);
        n_cmp++; if (ei !== 1'b0) begin n_bad++; $display("FAIL thr_ei_early got %0b want 0", ei); end
        idle(1);
        n_cmp++; if (ei !== 1'b1 || ei !== exp_ei) begin n_bad++; $display("FAIL thr_ei_rise got %0b want 1", ei); end
    endtask

    task automatic test_claim_hold();
        do_reset();
        src = 8'h08;
        tick(1'b1, 1'b1, 6'h01, 32'hFF);
        tick(1'b1, 1'b1, 6'h13, 32'd3);
        idle(2);
        n_cmp++; if (ei !== 1'b1) begin n_bad++; $display("FAIL hold_ei_pre got %0b want 1", ei); end
        tick(1'b1, 1'b0, 6'h03, 32'd0);
        n_cmp++; if (bus_rdata !== 32'd4) begin n_bad++; $display("FAIL hold_claim got %0d want 4", bus_rdata); end
        idle(1);
        n_cmp++; if (ei !== 1'b0) begin n_bad++; $display("FAIL hold_ei_drop got %0b want 0", ei); end
        tick(1'b1, 1'b0, 6'h00, 32'd0);
        n_cmp++; if (bus_rdata !== 32'd0) begin n_bad++; $display("FAIL hold_pending_in_service got %h want 0", bus_rdata); end
        tick(1'b1, 1'b1, 6'h03, 32'd4);
        tick(1'b1, 1'b0, 6'h00, 32'd0);
        n_cmp++; if (bus_rdata !== exp_rdata) begin n_bad++; $display("FAIL hold_pending_edge got %h want %h", bus_rdata, exp_rdata); end
        tick(1'b1, 1'b0, 6'h00, 32'd0);
        n_cmp++; if (bus_rdata !== 32'h08) begin n_bad++; $display("FAIL hold_pending_reset got %h want 08", bus_rdata); end
        idle(1);
        n_cmp++; if (ei !== 1'b1) begin n_bad++; $display("FAIL hold_ei_back got %0b want 1", ei); end
    endtask

    task automatic test_bad_complete();
        logic [31:0] ids [3];
        ids[0] = 32'd0; ids[1] = 32'd9; ids[2] = 32'd3;
        do_reset();
        src = 8'h02;
        tick(1'b1, 1'b1, 6'h01, 32'hFF);
        tick(1'b1, 1'b1, 6'h11, 32'd2);
        tick(1'b1, 1'b0, 6'h03, 32'd0);
        n_cmp++; if (bus_rdata !== 32'd2) begin n_bad++; $display("FAIL badc_claim got %0d want 2", bus_rdata); end
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b1, 6'h03, ids[k]);
            n_cmp++; if (bus_ack !== 1'b1) begin n_bad++; $display("FAIL badc_ack[%0d] got %0b want 1", k, bus_ack); end
            idle(1);
            n_cmp++; if (bus_ack !== 1'b0) begin n_bad++; $display("FAIL badc_ack_low[%0d] got %0b want 0", k, bus_ack); end
        end
        tick(1'b1, 1'b0, 6'h00, 32'd0);
        n_cmp++; if (bus_rdata !== 32'd0 || bus_rdata !== exp_rdata) begin n_bad++; $display("FAIL badc_pending got %h want 0", bus_rdata); end
        tick(1'b1, 1'b1, 6'h03, 32'd2);
        idle(1);
        tick(1'b1, 1'b0, 6'h00, 32'd0);
        n_cmp++; if (bus_rdata !== 32'h02) begin n_bad++; $display("FAIL badc_real_complete got %h want 02", bus_rdata); end
    endtask

    task automatic test_edge();
`ifdef IRQ_EDGE_EN
        do_reset();
        src = 8'h00;
        tick(1'b1, 1'b1, 6'h04, 32'h01);
        tick(1'b1, 1'b1, 6'h10, 32'd2);
        tick(1'b1, 1'b1, 6'h01, 32'h01);
        for (int k = 0; k < 3; k++) begin
            src = 8'h01; idle(1);
            src = 8'h00; idle(1);
        end
        tick(1'b1, 1'b0, 6'h03, 32'd0);
        n_cmp++; if (bus_rdata !== 32'd1) begin n_bad++; $display("FAIL edge_claim1 got %0d want 1", bus_rdata); end
        tick(1'b1, 1'b0, 6'h03, 32'd0);
        n_cmp++; if (bus_rdata !== 32'd0) begin n_bad++; $display("FAIL edge_claim2 got %0d want 0", bus_rdata); end
        src = 8'h01; idle(1);
        src = 8'h00; idle(1);
        tick(1'b1, 1'b0, 6'h00, 32'd0);
        n_cmp++; if (bus_rdata !== 32'h01) begin n_bad++; $display("FAIL edge_repend got %h want 01", bus_rdata); end
        tick(1'b1, 1'b0, 6'h03, 32'd0);
        n_cmp++; if (bus_rdata !== 32'd0) begin n_bad++; $display("FAIL edge_blocked got %0d want 0", bus_rdata); end
        tick(1'b1, 1'b1, 6'h03, 32'd1);
        tick(1'b1, 1'b0, 6'h03, 32'd0);
        n_cmp++; if (bus_rdata !== 32'd1) begin n_bad++; $display("FAIL edge_reclaim got %0d want 1", bus_rdata); end
`else
        do_reset();
        tick(1'b1, 1'b1, 6'h04, 32'hFF);
        tick(1'b1, 1'b0, 6'h04, 32'd0);
        n_cmp++; if (bus_rdata !== 32'd0) begin n_bad++; $display("FAIL edge_reg_absent got %h want 0", bus_rdata); end
`endif
    endtask

    task automatic test_random();
        logic [5:0] a;
        int op;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) src = 8'($urandom);
            op = $urandom_range(0, 9);
            a = ($urandom_range(0, 1) == 1) ? 6'(16 + $urandom_range(0, 8)) : 6'($urandom_range(0, 5));
            if ($urandom_range(0, 20) == 0) a = 6'h3F;
            case (op)
                0, 1, 2: tick(1'b0, 1'b0, 6'h00, 32'd0);
                3, 4:    tick(1'b1, 1'b0, 6'h03, 32'd0);
                5:       tick(1'b1, 1'b1, 6'h03, 32'($urandom_range(0, 10)));
                6, 7:    tick(1'b1, 1'b1, a, $urandom);
                default: tick(1'b1, 1'b0, a, 32'd0);
            endcase
            n_cmp++; if (bus_ack !== exp_ack) begin n_bad++; $display("FAIL rnd_ack[%0d] got %0b want %0b", n, bus_ack, exp_ack); end
            n_cmp++; if (bus_rdata !== exp_rdata) begin n_bad++; $display("FAIL rnd_rdata[%0d] addr %h got %h want %h", n, bus_addr, bus_rdata, exp_rdata); end
            n_cmp++; if (ei !== exp_ei) begin n_bad++; $display("FAIL rnd_ei[%0d] got %0b want %0b", n, ei, exp_ei); end
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_threshold();
        test_claim_hold();
        test_bad_complete();
        test_edge();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
